mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-master arbiter sharing the single memory port between the CPU core (master 0) and a second bus master (master 1, e.g. DMA or debug loader).
- Both masters and the downstream memory use the core's strobe handshake: one-cycle init strobe with op/addr/wdata, then a one-cycle ready pulse.
- Captures each master's strobed request, grants one at a time, forwards it downstream and returns the ready pulse and rdata to the owner only.

Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- m0_init  in  1  CPU request strobe, one cycle
- m0_read_op  in  3  CPU read op, opaque, forwarded
- m0_write_op  in  2  CPU write op, opaque, forwarded
- m0_addr  in  AW  CPU address
- m0_wdata  in  DW  CPU write data
- m0_ready  out  1  CPU completion pulse
- m0_rdata  out  DW  CPU read data, valid while m0_ready=1
- m1_init, m1_read_op, m1_write_op, m1_addr, m1_wdata, m1_ready, m1_rdata: same as m0_*, for master 1
- s_init  out  1  downstream request strobe
- s_read_op  out  3  downstream read op
- s_write_op  out  2  downstream write op
- s_addr  out  AW  downstream address
- s_wdata  out  DW  downstream write data
- s_ready  in  1  downstream completion pulse, one per transaction, for reads and writes
- s_rdata  in  DW  downstream read data, sampled when s_ready=1

Behaviour:
- Reset: asynchronous, active-high. Clears both pending slots and sets state=IDLE. All outputs are 0: s_init, s_*op, s_addr, s_wdata, mX_ready, mX_rdata. Round-robin pointer resets to master 0.
- Capture: mX_init=1 latches the op, addr and wdata into slot X and sets pend[X] on the next edge.
- Init while pend[X]=1 or slot X is in flight is a protocol violation and is ignored; the slot keeps its contents.
- Init in the same cycle mX_ready=1 is legal and is captured.
- FSM:
  - IDLE: if any pend bit is set, select the winner, load the s_* registers from its slot, clear its pend bit, set owner, go to ISSUE.
  - ISSUE: s_init=1 for exactly one cycle, then go to WAIT.
  - WAIT: hold s_* stable. On s_ready: register s_rdata into m{owner}_rdata, pulse m{owner}_ready for one cycle on the next edge, go to IDLE.
- Selection: fixed priority, master 0 (CPU) wins when both are pending.
- Latency: mX_init at cycle t gives s_init at t+2 when the arbiter is idle. s_ready at cycle u gives mX_ready at u+1.
- Minimum spacing between back-to-back downstream strobes: 3 cycles.
- s_ready outside WAIT is a stray pulse and is ignored; no mX_ready is generated.
- Non-owner mX_ready stays 0 and its mX_rdata holds its previous value.
- Reset during WAIT abandons the transaction; a late s_ready after reset is ignored.

Optional Feature:
- Macro: MEM_ARBITER_RR_EN.
- Defined: round-robin selection. When both masters are pending, the winner is the master not granted last. The pointer updates on each grant.
- Not defined: fixed priority as above; the pointer logic is absent.

Decomposition:
- Package mem_arbiter_pkg holds:
  - state enum: IDLE, ISSUE, WAIT
  - READ_OP_W=3, WRITE_OP_W=2
  - master index constants M_CPU=0, M_AUX=1
- Sub-module mem_req_slot, instantiated per master: capture registers plus the pend flag, with ports clk, reset, init, busy, clear, op/addr/wdata in and out, pend.

Test Plan:
- Single CPU read: m0_init with addr=0x100, read_op=3'b010; s_ready 3 cycles later with s_rdata=0xDEADBEEF -> s_init at t+2 with s_addr=0x100; m0_ready pulse with m0_rdata=0xDEADBEEF one cycle after s_ready; m1_ready stays 0.
- Simultaneous m0_init (0x10) and m1_init (0x20):
  - Without the macro: CPU is served first, then master 1.
  - With MEM_ARBITER_RR_EN and last grant=0: 0x20 is served first.
- Master 1 write with write_op=2'b11, wdata=0x55AA: s_wdata=0x55AA stays stable from ISSUE through s_ready; one m1_ready pulse results.
- Repeated m0_init while pending with addr 0x40 then 0x44: only 0x40 is issued; exactly one m0_ready.
- Stray s_ready while IDLE: no mX_ready pulse and no state change.
- Reset asserted mid-WAIT, then s_ready: all outputs drop to 0 asynchronously; no ready pulse; next m1_init is served normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int READ_OP_W  = 3;
    localparam int WRITE_OP_W = 2;

    localparam bit M_CPU = 1'b0;
    localparam bit M_AUX = 1'b1;

endpackage

// File: rtl/mem_req_slot.sv
// One master's request holding slot: latches a strobed request and flags it pending
// until the arbiter takes it.
module mem_req_slot
    import mem_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic                  busy,
    input  logic                  clear,
    input  logic [READ_OP_W-1:0]  read_op_in,
    input  logic [WRITE_OP_W-1:0] write_op_in,
    input  logic [AW-1:0]         addr_in,
    input  logic [DW-1:0]         wdata_in,
    output logic [READ_OP_W-1:0]  read_op_out,
    output logic [WRITE_OP_W-1:0] write_op_out,
    output logic [AW-1:0]         addr_out,
    output logic [DW-1:0]         wdata_out,
    output logic                  pend
);

    logic                  r_pend;
    logic [READ_OP_W-1:0]  r_read_op;
    logic [WRITE_OP_W-1:0] r_write_op;
    logic [AW-1:0]         r_addr;
    logic [DW-1:0]         r_wdata;

    // A new strobe is only accepted when nothing from this master is queued or in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend     <= 1'b0;
            r_read_op  <= '0;
            r_write_op <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else if (init && !r_pend && !busy) begin
            r_pend     <= 1'b1;
            r_read_op  <= read_op_in;
            r_write_op <= write_op_in;
            r_addr     <= addr_in;
            r_wdata    <= wdata_in;
        end else if (clear) begin
            r_pend     <= 1'b0;
        end
    end

    assign pend         = r_pend;
    assign read_op_out  = r_read_op;
    assign write_op_out = r_write_op;
    assign addr_out     = r_addr;
    assign wdata_out    = r_wdata;

endmodule

// File: rtl/mem_arbiter.sv
// Two-master strobe-handshake memory arbiter. Fixed priority (CPU first) by default;
// define MEM_ARBITER_RR_EN for round-robin selection between simultaneous requests.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_init,
    input  logic [READ_OP_W-1:0]  m0_read_op,
    input  logic [WRITE_OP_W-1:0] m0_write_op,
    input  logic [AW-1:0]         m0_addr,
    input  logic [DW-1:0]         m0_wdata,
    output logic                  m0_ready,
    output logic [DW-1:0]         m0_rdata,
    input  logic                  m1_init,
    input  logic [READ_OP_W-1:0]  m1_read_op,
    input  logic [WRITE_OP_W-1:0] m1_write_op,
    input  logic [AW-1:0]         m1_addr,
    input  logic [DW-1:0]         m1_wdata,
    output logic                  m1_ready,
    output logic [DW-1:0]         m1_rdata,
    output logic                  s_init,
    output logic [READ_OP_W-1:0]  s_read_op,
    output logic [WRITE_OP_W-1:0] s_write_op,
    output logic [AW-1:0]         s_addr,
    output logic [DW-1:0]         s_wdata,
    input  logic                  s_ready,
    input  logic [DW-1:0]         s_rdata
);

    state_t r_state, w_next;
    logic   r_owner;
    logic   w_grant;
    logic   w_sel;
    logic   w_pend0, w_pend1;
    logic   w_busy0, w_busy1;
    logic   w_clear0, w_clear1;

    logic [READ_OP_W-1:0]  w_rop0, w_rop1;
    logic [WRITE_OP_W-1:0] w_wop0, w_wop1;
    logic [AW-1:0]         w_addr0, w_addr1;
    logic [DW-1:0]         w_wdata0, w_wdata1;

    logic [READ_OP_W-1:0]  r_s_read_op;
    logic [WRITE_OP_W-1:0] r_s_write_op;
    logic [AW-1:0]         r_s_addr;
    logic [DW-1:0]         r_s_wdata;
    logic [1:0]            r_m_ready;
    logic [DW-1:0]         r_m0_rdata, r_m1_rdata;

    assign w_busy0  = (r_state != IDLE) && (r_owner == M_CPU);
    assign w_busy1  = (r_state != IDLE) && (r_owner == M_AUX);
    assign w_clear0 = w_grant && (w_sel == M_CPU);
    assign w_clear1 = w_grant && (w_sel == M_AUX);

    mem_req_slot #(.AW(AW), .DW(DW)) u_slot0 (
        .clk          (clk),
        .reset        (reset),
        .init         (m0_init),
        .busy         (w_busy0),
        .clear        (w_clear0),
        .read_op_in   (m0_read_op),
        .write_op_in  (m0_write_op),
        .addr_in      (m0_addr),
        .wdata_in     (m0_wdata),
        .read_op_out  (w_rop0),
        .write_op_out (w_wop0),
        .addr_out     (w_addr0),
        .wdata_out    (w_wdata0),
        .pend         (w_pend0)
    );

    mem_req_slot #(.AW(AW), .DW(DW)) u_slot1 (
        .clk          (clk),
        .reset        (reset),
        .init         (m1_init),
        .busy         (w_busy1),
        .clear        (w_clear1),
        .read_op_in   (m1_read_op),
        .write_op_in  (m1_write_op),
        .addr_in      (m1_addr),
        .wdata_in     (m1_wdata),
        .read_op_out  (w_rop1),
        .write_op_out (w_wop1),
        .addr_out     (w_addr1),
        .wdata_out    (w_wdata1),
        .pend         (w_pend1)
    );

`ifdef MEM_ARBITER_RR_EN
    // r_last remembers the most recent grant; a tie goes to the other master.
    logic r_last;

    always_comb begin
        w_sel = ~w_pend0;
        if (w_pend0 && w_pend1) w_sel = ~r_last;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        r_last <= M_CPU;
        else if (w_grant) r_last <= w_sel;
    end
`else
    assign w_sel = ~w_pend0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pend0 || w_pend1) begin
                    w_grant = 1'b1;
                    w_next  = ISSUE;
                end
            end
            ISSUE:   w_next = WAIT;
            WAIT:    if (s_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner      <= M_CPU;
            r_s_read_op  <= '0;
            r_s_write_op <= '0;
            r_s_addr     <= '0;
            r_s_wdata    <= '0;
            r_m_ready    <= '0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
        end else begin
            r_m_ready <= '0;
            if (w_grant) begin
                r_owner      <= w_sel;
                r_s_read_op  <= w_sel ? w_rop1   : w_rop0;
                r_s_write_op <= w_sel ? w_wop1   : w_wop0;
                r_s_addr     <= w_sel ? w_addr1  : w_addr0;
                r_s_wdata    <= w_sel ? w_wdata1 : w_wdata0;
            end
            // Completion is only honoured in WAIT; stray pulses elsewhere fall through.
            if (r_state == WAIT && s_ready) begin
                r_m_ready <= {r_owner, ~r_owner};
                if (r_owner == M_AUX) r_m1_rdata <= s_rdata;
                else                  r_m0_rdata <= s_rdata;
            end
        end
    end

    assign s_init     = (r_state == ISSUE);
    assign s_read_op  = r_s_read_op;
    assign s_write_op = r_s_write_op;
    assign s_addr     = r_s_addr;
    assign s_wdata    = r_s_wdata;
    assign m0_ready   = r_m_ready[0];
    assign m1_ready   = r_m_ready[1];
    assign m0_rdata   = r_m0_rdata;
    assign m1_rdata   = r_m1_rdata;

endmodule
